sha256_round_sequencer: RTL
===========================

# sha256_round_sequencer

Control block that drives one `sha256_chunk_compress` datapath through each 512-bit chunk. It accepts message words over a valid/ready stream and expands them into the 64-entry message schedule W[t]. It issues W[t] and K[t] one round per cycle, then commands the final H += a..h update. It also sequences per-message re-initialisation of the hash state and flags when the digest on the datapath outputs is final.

## Interface
- No parameters. Round count is fixed at 64 and chunk size at 16 words.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: message word valid.
- `in_ready` out 1: word accepted when `in_valid & in_ready`.
- `in_data` in 32: message word, big-endian. [31:24] is the earlier byte.
- `in_new_msg` in 1: sampled with word 0 of a chunk. 1 means the chunk is the first chunk of a message.
- `in_last` in 1: sampled with word 0 of a chunk. 1 means the chunk is the last (padded) chunk.
- `core_rst_n` out 1: to datapath `rst_n`. Registered and glitch-free.
- `core_enable` out 1: to datapath `enable`. Registered and glitch-free, because low asynchronously reloads the working variables.
- `core_update` out 1: to datapath `update`.
- `core_w` out 32: to datapath `w_in`.
- `core_k` out 32: to datapath `k_in`.
- `busy` out 1: chunk in progress.
- `digest_valid` out 1: one-cycle pulse when the datapath hash outputs hold a final message digest.

## Operation
- State LOAD:
  - `in_ready`=1; word counter `wc` 0..15.
  - Each accepted word shifts into a 16×32 schedule register: `ws[15]` ← new word, and `ws[i]` ← `ws[i+1]`.
  - Word 0 latches `in_new_msg` and `in_last`. If `in_new_msg`=1, `core_rst_n` goes low for exactly the next cycle, restoring the IV.
  - Acceptance of word 15 moves to ROUND with t=0.
- State ROUND, t=0..63:
  - `core_enable`=1, `core_w`=W[t]=`ws[0]`, `core_k`=K[t].
  - Every cycle the schedule shifts left and appends σ1(`ws[14]`) + `ws[9]` + σ0(`ws[1]`) + `ws[0]`, mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t=63 moves to UPDATE.
- State UPDATE:
  - `core_enable`=1 and `core_update`=1 for one cycle. `core_w`/`core_k` are don't-care.
  - Moves to SETTLE.
- State SETTLE:
  - `core_enable`=0 for one cycle, so the working variables reload from the updated H.
  - `digest_valid`=1 if the latched last flag is set.
  - Moves to LOAD with wc=0.
- All arithmetic is 32-bit modular; carries are dropped.
- `in_new_msg`/`in_last` on words 1..15 are ignored.
- `busy` = (state≠LOAD) | (wc≠0).
- The datapath retains the digest until the next `in_new_msg` chunk starts. No ready from the downstream consumer is modelled.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` low, 1 after release.
  - `core_rst_n`=0, `core_enable`=0, `core_update`=0.
  - `core_w`=0, `core_k`=0, `busy`=0, `digest_valid`=0.
  - State LOAD, wc=0, `ws`=0.
- `core_w`, `core_k`, `core_enable`, `core_update` and `core_rst_n` are all register outputs. K[t] is fetched from the ROM one cycle ahead.
- With `in_valid` held high, word 0 is accepted at cycle 0. Then:
  - Words are accepted in cycles 0–15.
  - ROUND occupies cycles 16–79.
  - UPDATE is cycle 80.
  - SETTLE is cycle 81, with `digest_valid` pulsing if last.
  - The next word 0 is accepted at cycle 82.
  - Throughput is 82 cycles per chunk.
- Backpressure (`in_valid` low) stalls LOAD only. ROUND/UPDATE/SETTLE never stall, and `in_ready`=0 throughout them.
- `rst_n` asserted mid-chunk aborts immediately to reset values. The partial chunk is discarded and the datapath IV is restored.

## Structure
- Shared package `sha256_pkg` holds:
  - the K[0..63] constant array;
  - the IV constants;
  - the σ0/σ1 functions;
  - the state enum {LOAD, ROUND, UPDATE, SETTLE}.
- One sub-module, `sha256_msg_schedule`: the 16×32 shift register plus expansion logic. Inputs are load/shift strobes and the word in; output is `ws[0]`.
- The FSM, counters, K fetch and output registers stay in `sha256_round_sequencer`.

## Test plan
- "abc" single chunk, with the core attached and `in_valid` held high.
  - Stimulus: words 0x61626380, 14×0x00000000, 0x00000018; `in_new_msg`=1, `in_last`=1.
  - Required: `core_w` at t=16 is 0x61626380 and at t=17 is 0x000F0000.
  - Required: `digest_valid` pulses at cycle 81.
  - Required: raw H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-chunk message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
  - Required: no `digest_valid` after chunk 1.
  - Required: after chunk 2, digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: "abc" with `in_valid` toggling 1-0-1.
  - Required: the same digest; ROUND starts exactly one cycle after word 15 is accepted.
  - Required: `in_ready`=0 for all 66 non-LOAD cycles.
- Back-to-back messages: "abc" then "abc" again with `in_new_msg`=1.
  - Required: a one-cycle `core_rst_n` low pulse after word 0 of the second message.
  - Required: an identical second digest.
- Reset mid-round: assert `rst_n` low at t=30, then resend "abc".
  - Required: all outputs at reset values during reset; the correct digest afterwards.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the round sequencer slice.
// Contents: sequencer state enum, round constant table K[0..63], initial hash
// value IV[0..7], K lookup helper and the message-schedule sigma functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ROUND  = 2'd1,
    UPDATE = 2'd2,
    SETTLE = 2'd3
  } seq_state_e;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV_TABLE [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16x32 SHA-256 message schedule window with in-place expansion.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears the window)
//   load        - shift in word_in at ws[15] (message load phase)
//   shift       - shift in the expanded word W[t+16] at ws[15] (round phase)
//   word_in     - incoming message word
//   w_next      - ws[1], i.e. the word that becomes ws[0] after the next strobe.
//                 The sequencer registers this so its core_w output shows
//                 ws[0] in the cycle the datapath consumes it.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] word_in,
  output logic [31:0] w_next
);

  logic [31:0] ws [16];
  logic [31:0] expand;

  // W[t+16] from the window holding W[t..t+15]; carries dropped
  assign expand = sigma1(ws[14]) + ws[9] + sigma0(ws[1]) + ws[0];
  assign w_next = ws[1];

  // window shift register: shift left, append either the message word or W[t+16]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ws[i] <= 32'h0;
      end
    end else if (load || shift) begin
      for (int i = 0; i < 15; i++) begin
        ws[i] <= ws[i + 1];
      end
      ws[15] <= load ? word_in : expand;
    end
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// SHA-256 round sequencer: loads a 16-word chunk over a valid/ready stream,
// then drives one sha256_chunk_compress datapath through 64 rounds, the H
// update and a settle cycle (82 cycles per chunk with no input stalls).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  - message word stream (big-endian words)
//   in_new_msg, in_last        - chunk flags, sampled with word 0 only
//   core_rst_n                 - datapath reset, low one cycle to restore the IV
//   core_enable                - datapath enable, low reloads a..h from H
//   core_update                - datapath H += a..h command
//   core_w, core_k             - W[t] and K[t] for the current round
//   busy                       - chunk in progress
//   digest_valid               - one-cycle pulse: datapath H is a final digest
module sha256_round_sequencer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_new_msg,
  input  logic        in_last,
  output logic        core_rst_n,
  output logic        core_enable,
  output logic        core_update,
  output logic [31:0] core_w,
  output logic [31:0] core_k,
  output logic        busy,
  output logic        digest_valid
);

  seq_state_e  state, state_next;
  logic [3:0]  wc, wc_next;
  logic [5:0]  rc, rc_next;
  logic        last_flag, last_next;
  logic        accept;
  logic        sched_load, sched_shift;
  logic [31:0] sched_next;

  assign accept = in_valid & in_ready;

  sha256_msg_schedule u_schedule (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sched_load),
    .shift   (sched_shift),
    .word_in (in_data),
    .w_next  (sched_next)
  );

  // state, word counter, round counter and latched last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wc        <= 4'd0;
      rc        <= 6'd0;
      last_flag <= 1'b0;
    end else begin
      state     <= state_next;
      wc        <= wc_next;
      rc        <= rc_next;
      last_flag <= last_next;
    end
  end

  // next-state logic and schedule strobes
  always_comb begin
    state_next  = state;
    wc_next     = wc;
    rc_next     = rc;
    last_next   = last_flag;
    sched_load  = 1'b0;
    sched_shift = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          sched_load = 1'b1;
          wc_next    = wc + 4'd1;  // wraps to 0 after word 15
          if (wc == 4'd0) begin
            last_next = in_last;
          end else begin
            last_next = last_flag;
          end
          if (wc == 4'd15) begin
            state_next = ROUND;
            rc_next    = 6'd0;
          end else begin
            state_next = LOAD;
          end
        end else begin
          state_next = LOAD;
        end
      end
      ROUND: begin
        sched_shift = 1'b1;
        rc_next     = rc + 6'd1;
        if (rc == 6'd63) begin
          state_next = UPDATE;
        end else begin
          state_next = ROUND;
        end
      end
      UPDATE:  state_next = SETTLE;
      SETTLE:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // registered outputs, computed from the next state so they line up with it;
  // K is looked up with the next round index (one cycle ahead of use)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      core_rst_n   <= 1'b0;
      core_enable  <= 1'b0;
      core_update  <= 1'b0;
      core_w       <= 32'h0;
      core_k       <= 32'h0;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      in_ready     <= (state_next == LOAD);
      core_rst_n   <= ~(accept & (wc == 4'd0) & in_new_msg);
      core_enable  <= (state_next == ROUND) | (state_next == UPDATE);
      core_update  <= (state_next == UPDATE);
      core_w       <= (state_next == ROUND) ? sched_next : 32'h0;
      core_k       <= (state_next == ROUND) ? k_rom(rc_next) : 32'h0;
      busy         <= (state_next != LOAD) | (wc_next != 4'd0);
      digest_valid <= (state_next == SETTLE) & last_flag;
    end
  end

endmodule
